// File: rtl/keypad_pkg.sv
// Shared key codes, command codes, FSM state types and the matrix key map
// for the keypad command generator.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] CMD_ARM    = 4'b0011;
  localparam logic [3:0] CMD_DISARM = 4'b1100;
  localparam logic [3:0] CMD_NONE   = 4'b0000;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWaitCmd,
    StHoldCmd,
    StLockout
  } entry_state_e;

  typedef enum logic [1:0] {
    ScScan,
    ScPress,
    ScHeld
  } scan_state_e;

  // Key index is 4*row + col.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    unique case ({row, col})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = KEY_A;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = KEY_B;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = KEY_C;
      4'd12: code = KEY_STAR;
      4'd13: code = 4'h0;
      4'd14: code = KEY_HASH;
      4'd15: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_cmd_gen_if.sv
// Keypad matrix and alarm-controller signals of the keypad command generator.
interface keypad_cmd_gen_if;
  logic [3:0] rows;
  logic [3:0] col_drive;
  logic [3:0] keypad;
  logic       cmd_valid;
  logic       entry_busy;
  logic       locked_out;

  modport slave (
    input  rows,
    output col_drive,
    output keypad,
    output cmd_valid,
    output entry_busy,
    output locked_out
  );

  modport master (
    output rows,
    input  col_drive,
    input  keypad,
    input  cmd_valid,
    input  entry_busy,
    input  locked_out
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner with press/release debounce; emits one key event per
// debounced press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_VAL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic [3:0] rows_i,
  output logic [3:0] col_drive_o,
  output logic       key_evt_o,
  output logic [3:0] key_code_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_VAL + 1);

  scan_state_e st_q, st_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]  row_now;
  logic        any_row;

  always_comb begin
    row_now = 2'd0;
    if (rows_i[0])      row_now = 2'd0;
    else if (rows_i[1]) row_now = 2'd1;
    else if (rows_i[2]) row_now = 2'd2;
    else if (rows_i[3]) row_now = 2'd3;
  end

  assign any_row = rows_i != 4'b0000;

  always_comb begin
    st_d      = st_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    key_evt_o = 1'b0;
    unique case (st_q)
      ScScan: begin
        if (any_row) begin
          row_d = row_now;
          cnt_d = CntW'(1);
          st_d  = ScPress;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      ScPress: begin
        if (!any_row) begin
          cnt_d = '0;
          st_d  = ScScan;
        end else if (row_now != row_q) begin
          row_d = row_now;
          cnt_d = CntW'(1);
        end else if (cnt_q == CntW'(DEBOUNCE_VAL - 1)) begin
          key_evt_o = ENA;
          cnt_d     = '0;
          st_d      = ScHeld;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ScHeld: begin
        // Release must be stable too; any row activity restarts the count.
        if (any_row) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_VAL - 1)) begin
          cnt_d = '0;
          st_d  = ScScan;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d = '0;
        st_d  = ScScan;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ENA) begin
      if (reset) begin
        st_q  <= ScScan;
        col_q <= 2'd0;
        row_q <= 2'd0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        col_q <= col_d;
        row_q <= row_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign col_drive_o = 4'b0001 << col_q;
  assign key_code_o  = key_map(row_q, col_q);

endmodule

// File: rtl/keypad_cmd_gen.sv
// Keypad command generator: PIN entry FSM, PIN compare, fail counter,
// command hold and lockout timers around the matrix scanner.
module keypad_cmd_gen
  import keypad_pkg::*;
#(
  parameter logic [15:0] PIN          = 16'h1234,
  parameter int unsigned DEBOUNCE_VAL = 10,
  parameter int unsigned CMD_HOLD     = 4,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned LOCK_CYCLES  = 200
) (
  input logic              clk,
  input logic              reset,
  input logic              ENA,
  keypad_cmd_gen_if.slave  bus
);

  localparam int unsigned HoldW = $clog2(CMD_HOLD + 1);
  localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);
  localparam int unsigned DigW  = $clog2(5);

  logic       key_evt;
  logic [3:0] key_code;
  logic [3:0] col_drive;
  logic       is_cmd;

  entry_state_e     state_q, state_d;
  logic [15:0]      pin_buf_q, pin_buf_d;
  logic [DigW-1:0]  dcnt_q, dcnt_d;
  logic [FailW-1:0] fail_q, fail_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic [3:0]       keypad_q, keypad_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;

  keypad_scanner #(
    .DEBOUNCE_VAL(DEBOUNCE_VAL)
  ) u_scanner (
    .clk         (clk),
    .reset       (reset),
    .ENA         (ENA),
    .rows_i      (bus.rows),
    .col_drive_o (col_drive),
    .key_evt_o   (key_evt),
    .key_code_o  (key_code)
  );

  assign is_cmd = (key_code == KEY_A) || (key_code == KEY_D);

  always_comb begin
    state_d   = state_q;
    pin_buf_d = pin_buf_q;
    dcnt_d    = dcnt_q;
    fail_d    = fail_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    keypad_d  = keypad_q;
    unique case (state_q)
      StIdle, StCollect, StWaitCmd: begin
        if (key_evt) begin
          if (is_digit(key_code)) begin
            if (state_q == StCollect) begin
              pin_buf_d = {pin_buf_q[11:0], key_code};
              dcnt_d    = dcnt_q + DigW'(1);
              if (dcnt_q == DigW'(3)) state_d = StWaitCmd;
            end else begin
              pin_buf_d = {12'h000, key_code};
              dcnt_d    = DigW'(1);
              state_d   = StCollect;
            end
          end else if ((key_code == KEY_C) || (is_cmd && (state_q != StWaitCmd))) begin
            pin_buf_d = '0;
            dcnt_d    = '0;
            state_d   = StIdle;
          end else if (is_cmd) begin
            pin_buf_d = '0;
            dcnt_d    = '0;
            if (pin_buf_q == PIN) begin
              fail_d   = '0;
              hold_d   = '0;
              keypad_d = (key_code == KEY_A) ? CMD_ARM : CMD_DISARM;
              state_d  = StHoldCmd;
            end else if (fail_q == FailW'(MAX_FAILS - 1)) begin
              fail_d  = FailW'(MAX_FAILS);
              lock_d  = '0;
              state_d = StLockout;
            end else begin
              fail_d  = fail_q + FailW'(1);
              state_d = StIdle;
            end
          end
        end
      end
      StHoldCmd: begin
        if (hold_q == HoldW'(CMD_HOLD - 1)) begin
          hold_d   = '0;
          keypad_d = CMD_NONE;
          state_d  = StIdle;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StLockout: begin
        if (lock_q == LockW'(LOCK_CYCLES - 1)) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = StIdle;
        end else begin
          lock_d = lock_q + LockW'(1);
        end
      end
      default: begin
        keypad_d = CMD_NONE;
        state_d  = StIdle;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  assign valid_d  = keypad_d != CMD_NONE;
  assign busy_d   = (state_d == StCollect) || (state_d == StWaitCmd);
  assign locked_d = state_d == StLockout;

  always_ff @(posedge clk) begin
    if (ENA) begin
      if (reset) begin
        state_q   <= StIdle;
        pin_buf_q <= '0;
        dcnt_q    <= '0;
        fail_q    <= '0;
        hold_q    <= '0;
        lock_q    <= '0;
        keypad_q  <= CMD_NONE;
        valid_q   <= 1'b0;
        busy_q    <= 1'b0;
        locked_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        pin_buf_q <= pin_buf_d;
        dcnt_q    <= dcnt_d;
        fail_q    <= fail_d;
        hold_q    <= hold_d;
        lock_q    <= lock_d;
        keypad_q  <= keypad_d;
        valid_q   <= valid_d;
        busy_q    <= busy_d;
        locked_q  <= locked_d;
      end
    end
  end

  assign bus.col_drive  = col_drive;
  assign bus.keypad     = keypad_q;
  assign bus.cmd_valid  = valid_q;
  assign bus.entry_busy = busy_q;
  assign bus.locked_out = locked_q;

endmodule
